toggle_cov_collector: RTL
=========================

Name: toggle_cov_collector

Overview:
- Hardware toggle-coverage collector for a bus of nets. It samples the nets each enabled cycle and keeps per-bit saturating counts of rising (0->1) and falling (1->0) transitions.
- On request, it walks all bits in order and streams a snapshot out over a valid/ready port. It can optionally clear the counters after a dump.
- It sits beside the observed design and feeds coverage-database export logic.

Parameters:
- WIDTH, 8, number of monitored nets (1..256).
- CNT_W, 8, width of each rise/fall counter; counters saturate at 2**CNT_W-1.
- IDX_W, $clog2(WIDTH) (minimum 1), width of the bit index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- sample_en  input  1  when high in IDLE, net_in is sampled and toggles are counted.
- net_in  input  WIDTH  monitored nets, synchronous to clk.
- clear_on_dump  input  1  sampled at dump start; 1 = zero all counters after the dump completes.
- dump_req  input  1  single-cycle request to start a dump; honoured only in IDLE.
- busy  output  1  high in DUMP or CLEAR.
- out_valid  output  1  snapshot entry valid.
- out_ready  input  1  consumer accepts entry when out_valid && out_ready.
- out_idx  output  IDX_W  bit index of the current entry.
- out_rise  output  CNT_W  rise count of bit out_idx.
- out_fall  output  CNT_W  fall count of bit out_idx.
- out_covered  output  1  (out_rise != 0) && (out_fall != 0).
- out_last  output  1  high with the entry for index WIDTH-1.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All counters, prev register, prev_valid, index and the latched clear flag go to 0.
  - State goes to IDLE.
  - busy, out_valid, out_last go to 0; out_idx, out_rise, out_fall, out_covered go to 0.
  - Reset mid-dump abandons the dump; no further entries appear.
- prev tracking:
  - prev <= net_in on every cycle in which sample_en is high, in any state.
  - prev_valid is set on the first such cycle.
  - The first sample after reset only loads prev; no toggle is counted.
- Counting: only in IDLE, when sample_en && prev_valid.
  - For bit i: rise[i]++ if prev[i]==0 && net_in[i]==1; fall[i]++ if prev[i]==1 && net_in[i]==0.
  - Increments saturate; no wrap to 0.
  - The count is visible one cycle after the sampled edge.
- Counting is frozen in DUMP and CLEAR, so the snapshot stays consistent. prev keeps tracking, so no spurious toggle is counted on return to IDLE. Transitions that occur while frozen are lost by design.
- FSM states: IDLE, DUMP, CLEAR.
  - IDLE -> DUMP when dump_req:
    - idx <= 0; clear flag <= clear_on_dump.
    - out_valid rises on the next cycle (latency 1), and busy rises in the same cycle.
    - If the request cycle also samples a toggle, that toggle is counted before the freeze.
  - DUMP:
    - out_idx/out_rise/out_fall/out_covered/out_last are held stable while out_valid && !out_ready.
    - On handshake with idx < WIDTH-1: idx++ and the next entry is presented on the next cycle. There are no bubbles, so back-to-back handshakes give one entry per cycle.
  - DUMP, handshake on out_last:
    - out_valid drops on the next cycle.
    - Next state is CLEAR if the clear flag is set, else IDLE.
  - CLEAR: one cycle; all counters go to 0; prev_valid is unchanged. Then IDLE.
  - busy deasserts on entering IDLE.
- dump_req outside IDLE is ignored, not queued.
- WIDTH==1: a dump is a single entry, with out_last high on that entry.

Decomposition:
- Package toggle_cov_pkg:
  - typedef enum logic [1:0] {IDLE, DUMP, CLEAR} tc_state_e.
  - Default-width localparams.
  - A saturating-increment function.
- Sub-module toggle_bit_counter, instantiated WIDTH times:
  - Inputs: clk, rst_n, count_en, prev, cur, clr.
  - Outputs: rise and fall counters.
- The top level holds the FSM, the index and the output mux/registers.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles -> out_valid=0, busy=0; a later dump reports all rise=fall=0, covered=0.
- Basic toggle, WIDTH=8, sample_en=1:
  - Stimulus: net_in 0x00 -> 0x01 -> 0x00 -> 0x01 over 3 cycles.
  - Expected dump: idx0 rise=2, fall=1, covered=1; idx1..7 all 0.
  - First-sample check: net_in already 0x01 at the first sample -> not counted.
- Saturation, CNT_W=4: 40 full toggles of bit 3 -> rise=15, fall=15; no wrap.
- Backpressure:
  - out_ready low for 3 cycles on idx2 -> idx2 data stable throughout.
  - Then out_ready=1 continuously -> idx3..7 on consecutive cycles; out_last on idx7 only.
  - busy drops one cycle after the final handshake.
- Freeze and clear:
  - Toggle bit 0 during DUMP -> not counted; no extra count after return to IDLE.
  - clear_on_dump=1 -> one CLEAR cycle; an immediate second dump reports all zeros.
  - clear_on_dump=0 -> second dump repeats the first dump's values.
- Reset mid-dump: assert rst_n=0 at idx4 -> out_valid=0 next cycle, state IDLE, counters 0; a dump_req issued while busy (before the reset) is ignored.

Source files
------------

// File: rtl/toggle_cov_pkg.sv
// ---------------------------------------------------------------------------
// toggle_cov_pkg
// Shared definitions for the toggle-coverage collector:
//   tc_state_e   - collector FSM states (IDLE, DUMP, CLEAR)
//   TC_DEF_*     - default widths used by the collector and its bit counters
//   sat_inc()    - saturating increment for counters up to TC_MAX_CNT_W bits
// ---------------------------------------------------------------------------
package toggle_cov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMP  = 2'd1,
        CLEAR = 2'd2
    } tc_state_e;

    localparam int TC_DEF_WIDTH = 8;
    localparam int TC_DEF_CNT_W = 8;
    localparam int TC_MAX_CNT_W = 32;

    // Returns val+1, or val unchanged once it has reached the all-ones value
    // of a cnt_w-bit counter. Counters wider than TC_MAX_CNT_W are not supported.
    function automatic logic [TC_MAX_CNT_W-1:0] sat_inc(
        input logic [TC_MAX_CNT_W-1:0] val,
        input int                      cnt_w
    );
        logic [TC_MAX_CNT_W-1:0] max_val;
        if (cnt_w >= TC_MAX_CNT_W) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << cnt_w) - 32'd1;
        end
        if (val >= max_val) begin
            return max_val;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/toggle_bit_counter.sv
// ---------------------------------------------------------------------------
// toggle_bit_counter
// Rise/fall transition counters for a single monitored net.
// Ports:
//   clk       - clock, all updates on rising edge
//   rst_n     - synchronous active-low reset, zeroes both counters
//   count_en  - when high, a transition from prev to cur is counted
//   prev      - previously sampled value of the net
//   cur       - currently sampled value of the net
//   clr       - synchronous clear of both counters (wins over count_en)
//   rise      - saturating count of 0->1 transitions
//   fall      - saturating count of 1->0 transitions
// ---------------------------------------------------------------------------
module toggle_bit_counter
    import toggle_cov_pkg::*;
#(
    parameter int CNT_W = TC_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             prev,
    input  logic             cur,
    input  logic             clr,
    output logic [CNT_W-1:0] rise,
    output logic [CNT_W-1:0] fall
);

    // Counters hold at their maximum instead of wrapping, so a heavily
    // toggling net never looks uncovered after overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise <= '0;
            fall <= '0;
        end else if (clr) begin
            rise <= '0;
            fall <= '0;
        end else if (count_en) begin
            if (!prev && cur) begin
                rise <= CNT_W'(sat_inc(TC_MAX_CNT_W'(rise), CNT_W));
            end
            if (prev && !cur) begin
                fall <= CNT_W'(sat_inc(TC_MAX_CNT_W'(fall), CNT_W));
            end
        end
    end

endmodule

// File: rtl/toggle_cov_collector.sv
// ---------------------------------------------------------------------------
// toggle_cov_collector
// Samples a bus of nets each enabled cycle, keeps per-bit saturating rise and
// fall counts, and on request streams a snapshot of every bit over a
// valid/ready port, optionally clearing all counters afterwards.
// Ports:
//   clk           - clock, all state updates on rising edge
//   rst_n         - synchronous active-low reset
//   sample_en     - sample net_in this cycle (counting only happens in IDLE)
//   net_in        - monitored nets
//   clear_on_dump - latched at dump start; 1 = zero counters after the dump
//   dump_req      - single-cycle dump request, honoured only in IDLE
//   busy          - high while dumping or clearing
//   out_valid     - snapshot entry valid
//   out_ready     - consumer accepts entry when out_valid && out_ready
//   out_idx       - bit index of the current entry
//   out_rise      - rise count of bit out_idx
//   out_fall      - fall count of bit out_idx
//   out_covered   - both rise and fall counts non-zero
//   out_last      - high with the entry for index WIDTH-1
// ---------------------------------------------------------------------------
module toggle_cov_collector
    import toggle_cov_pkg::*;
#(
    parameter int WIDTH = TC_DEF_WIDTH,
    parameter int CNT_W = TC_DEF_CNT_W,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] net_in,
    input  logic             clear_on_dump,
    input  logic             dump_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_rise,
    output logic [CNT_W-1:0] out_fall,
    output logic             out_covered,
    output logic             out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    tc_state_e        state;
    tc_state_e        state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             clr_flag;
    logic             clr_flag_nxt;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic             count_en;
    logic             clr_cnt;
    logic             handshake;
    logic [CNT_W-1:0] rise_cnt [WIDTH];
    logic [CNT_W-1:0] fall_cnt [WIDTH];
    logic [CNT_W-1:0] sel_rise;
    logic [CNT_W-1:0] sel_fall;

    assign count_en  = (state == IDLE) && sample_en && prev_valid;
    assign clr_cnt   = (state == CLEAR);
    assign out_valid = (state == DUMP);
    assign busy      = (state != IDLE);
    assign handshake = out_valid && out_ready;

    // prev keeps tracking the bus even while counting is frozen, so leaving
    // DUMP/CLEAR never produces a spurious toggle against a stale sample.
    // The first sample after reset only arms prev_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= net_in;
            prev_valid <= 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        toggle_bit_counter #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .count_en (count_en),
            .prev     (prev[i]),
            .cur      (net_in[i]),
            .clr      (clr_cnt),
            .rise     (rise_cnt[i]),
            .fall     (fall_cnt[i])
        );
    end

    // State, dump index and the clear-after-dump flag latched at request time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            clr_flag <= clr_flag_nxt;
        end
    end

    // Dump walks every index once; a request while busy is dropped, and the
    // CLEAR state lasts exactly one cycle.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        clr_flag_nxt = clr_flag;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt    = DUMP;
                    idx_nxt      = '0;
                    clr_flag_nxt = clear_on_dump;
                end
            end
            DUMP: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = clr_flag ? CLEAR : IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            CLEAR: begin
                state_nxt    = IDLE;
                clr_flag_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The counters are frozen during DUMP and idx only moves on a handshake,
    // so selecting straight from the counter array gives registered, stable
    // entry data and still includes a toggle counted on the request cycle.
    always_comb begin
        sel_rise = '0;
        sel_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_rise = rise_cnt[i];
                sel_fall = fall_cnt[i];
            end
        end
    end

    assign out_idx     = out_valid ? idx : '0;
    assign out_rise    = out_valid ? sel_rise : '0;
    assign out_fall    = out_valid ? sel_fall : '0;
    assign out_covered = out_valid && (sel_rise != '0) && (sel_fall != '0);
    assign out_last    = out_valid && (idx == LAST_IDX);

endmodule
